// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU
// operation codes, step encodings, strobe bundle and opcode classification.
package cpu_defs_pkg;

    // Instruction opcodes, IR[31:27]
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU operation codes seen by the datapath
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_INC  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_ROR  = 4'd6,
        ALU_ROL  = 4'd7,
        ALU_SHR  = 4'd8,
        ALU_SHRA = 4'd9,
        ALU_SHL  = 4'd10,
        ALU_MUL  = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_NEG  = 4'd13,
        ALU_NOT  = 4'd14
    } alu_op_t;

    // Control steps plus the two idle states
    typedef enum logic [3:0] {
        T0    = 4'd0,
        T1    = 4'd1,
        T2    = 4'd2,
        T3    = 4'd3,
        T4    = 4'd4,
        T5    = 4'd5,
        T6    = 4'd6,
        HALT  = 4'd7,
        PAUSE = 4'd8
    } step_t;

    // Execution shape of an instruction after fetch
    typedef enum logic [2:0] {
        CLS_BINARY,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_t;

    // All single-bit datapath strobes, so the decode can clear them in one go
    typedef struct packed {
        logic PCout;
        logic Zlowout;
        logic Zhighout;
        logic MDRout;
        logic MARin;
        logic PCin;
        logic MDRin;
        logic IRin;
        logic Yin;
        logic Zin;
        logic LOin;
        logic HIin;
        logic IncPC;
        logic Read;
        logic Gra;
        logic Grb;
        logic Grc;
        logic Rin;
        logic Rout;
    } strobes_t;

    // Map an opcode onto the step sequence it follows
    function automatic op_class_t classify_op(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: classify_op = CLS_BINARY;
            OP_MUL, OP_DIV:                  classify_op = CLS_MULDIV;
            OP_NEG, OP_NOT:                  classify_op = CLS_UNARY;
            OP_NOP:                          classify_op = CLS_NOP;
            OP_HALT:                         classify_op = CLS_HALT;
            default:                         classify_op = CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath (slave):
// the IR and stop request flow in, step strobes and status flow out.
interface control_sequencer_if;
    import cpu_defs_pkg::*;

    logic [31:0] IR;
    logic        stop;

    logic        PCout;
    logic        Zlowout;
    logic        Zhighout;
    logic        MDRout;
    logic        MARin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        LOin;
    logic        HIin;
    logic        IncPC;
    logic        Read;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    alu_op_t     alu_op;
    logic        run;
    logic        illegal;

    modport master (
        input  IR, stop,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin,
        output LOin, HIin, IncPC, Read,
        output Gra, Grb, Grc, Rin, Rout,
        output alu_op, run, illegal
    );

    modport slave (
        output IR, stop,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin,
        input  LOin, HIin, IncPC, Read,
        input  Gra, Grb, Grc, Rin, Rout,
        input  alu_op, run, illegal
    );

endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps through fetch and register-register ALU
// instructions one control step per clock, decoding strobes from the state.
module control_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    step_t      r_state;
    step_t      w_next_state;
    logic [3:0] r_wait;
    logic [3:0] w_next_wait;
    logic       r_rst_hold;

    strobes_t   w_s;
    alu_op_t    w_alu_op;
    alu_op_t    w_alu_exec;
    logic       w_run;
    logic       w_illegal;
    logic [4:0] w_op;
    op_class_t  w_class;
    step_t      w_end_state;
    logic       w_unused_ir;

    assign w_op        = bus.IR[31:27];
    assign w_class     = classify_op(w_op);
    assign w_unused_ir = ^bus.IR[26:0];
    // Last step of an instruction either returns to fetch or parks in PAUSE
    assign w_end_state = bus.stop ? PAUSE : T0;

    // State, wait counter and reset-hold registers
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments keep every register updating from
        // the same pre-edge values, so no ordering races between them.
        if (clear) begin
            r_state    <= T0;
            r_wait     <= WAIT_INIT;
            r_rst_hold <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_wait     <= w_next_wait;
            r_rst_hold <= 1'b0;
        end
    end

    // Opcode to ALU operation used in the compute step
    always_comb begin
        case (w_op)
            OP_ADD:  w_alu_exec = ALU_ADD;
            OP_SUB:  w_alu_exec = ALU_SUB;
            OP_AND:  w_alu_exec = ALU_AND;
            OP_OR:   w_alu_exec = ALU_OR;
            OP_ROR:  w_alu_exec = ALU_ROR;
            OP_ROL:  w_alu_exec = ALU_ROL;
            OP_SHR:  w_alu_exec = ALU_SHR;
            OP_SHRA: w_alu_exec = ALU_SHRA;
            OP_SHL:  w_alu_exec = ALU_SHL;
            OP_MUL:  w_alu_exec = ALU_MUL;
            OP_DIV:  w_alu_exec = ALU_DIV;
            OP_NEG:  w_alu_exec = ALU_NEG;
            OP_NOT:  w_alu_exec = ALU_NOT;
            default: w_alu_exec = ALU_NOP;
        endcase
    end

    // Next-state and Moore strobe decode of the current step
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned and no latch is inferred.
        w_s          = '0;
        w_alu_op     = ALU_NOP;
        w_run        = 1'b1;
        w_illegal    = 1'b0;
        w_next_state = r_state;
        w_next_wait  = r_wait;

        if (r_rst_hold) begin
            // The clock after clear shows the quiet reset state, then T0 runs
            w_next_state = T0;
            w_next_wait  = WAIT_INIT;
        end else begin
            case (r_state)
                T0: begin
                    w_s.PCout    = 1'b1;
                    w_s.MARin    = 1'b1;
                    w_s.IncPC    = 1'b1;
                    w_s.Zin      = 1'b1;
                    w_alu_op     = ALU_INC;
                    w_next_wait  = WAIT_INIT;
                    w_next_state = T1;
                end
                T1: begin
                    w_s.Read  = 1'b1;
                    w_s.MDRin = 1'b1;
                    // PC update happens once, on the first clock of the read
                    if (r_wait == WAIT_INIT) begin
                        w_s.Zlowout = 1'b1;
                        w_s.PCin    = 1'b1;
                    end
                    if (r_wait != 4'd0) begin
                        w_next_wait = r_wait - 4'd1;
                    end else begin
                        w_next_state = T2;
                    end
                end
                T2: begin
                    w_s.MDRout = 1'b1;
                    w_s.IRin   = 1'b1;
                    // nop and halt branch here on the word presented on IR
                    case (w_class)
                        CLS_NOP:  w_next_state = w_end_state;
                        CLS_HALT: w_next_state = HALT;
                        default:  w_next_state = T3;
                    endcase
                end
                T3: begin
                    case (w_class)
                        CLS_BINARY: begin
                            w_s.Grb      = 1'b1;
                            w_s.Rout     = 1'b1;
                            w_s.Yin      = 1'b1;
                            w_next_state = T4;
                        end
                        CLS_MULDIV: begin
                            w_s.Gra      = 1'b1;
                            w_s.Rout     = 1'b1;
                            w_s.Yin      = 1'b1;
                            w_next_state = T4;
                        end
                        CLS_UNARY: begin
                            w_s.Grb      = 1'b1;
                            w_s.Rout     = 1'b1;
                            w_s.Zin      = 1'b1;
                            w_alu_op     = w_alu_exec;
                            w_next_state = T4;
                        end
                        CLS_HALT: begin
                            w_next_state = HALT;
                        end
                        CLS_ILLEGAL: begin
                            w_illegal    = 1'b1;
                            w_next_state = w_end_state;
                        end
                        default: begin
                            w_next_state = w_end_state;
                        end
                    endcase
                end
                T4: begin
                    case (w_class)
                        CLS_BINARY: begin
                            w_s.Grc      = 1'b1;
                            w_s.Rout     = 1'b1;
                            w_s.Zin      = 1'b1;
                            w_alu_op     = w_alu_exec;
                            w_next_state = T5;
                        end
                        CLS_MULDIV: begin
                            w_s.Grb      = 1'b1;
                            w_s.Rout     = 1'b1;
                            w_s.Zin      = 1'b1;
                            w_alu_op     = w_alu_exec;
                            w_next_state = T5;
                        end
                        CLS_UNARY: begin
                            w_s.Zlowout  = 1'b1;
                            w_s.Gra      = 1'b1;
                            w_s.Rin      = 1'b1;
                            w_next_state = w_end_state;
                        end
                        default: begin
                            w_next_state = w_end_state;
                        end
                    endcase
                end
                T5: begin
                    case (w_class)
                        CLS_BINARY: begin
                            w_s.Zlowout  = 1'b1;
                            w_s.Gra      = 1'b1;
                            w_s.Rin      = 1'b1;
                            w_next_state = w_end_state;
                        end
                        CLS_MULDIV: begin
                            w_s.Zlowout  = 1'b1;
                            w_s.LOin     = 1'b1;
                            w_next_state = T6;
                        end
                        default: begin
                            w_next_state = w_end_state;
                        end
                    endcase
                end
                T6: begin
                    w_s.Zhighout = 1'b1;
                    w_s.HIin     = 1'b1;
                    w_next_state = w_end_state;
                end
                HALT: begin
                    w_run        = 1'b0;
                    w_next_state = HALT;
                end
                PAUSE: begin
                    w_run        = 1'b0;
                    w_next_state = bus.stop ? PAUSE : T0;
                end
                default: begin
                    w_next_state = T0;
                end
            endcase
        end
    end

    assign bus.PCout    = w_s.PCout;
    assign bus.Zlowout  = w_s.Zlowout;
    assign bus.Zhighout = w_s.Zhighout;
    assign bus.MDRout   = w_s.MDRout;
    assign bus.MARin    = w_s.MARin;
    assign bus.PCin     = w_s.PCin;
    assign bus.MDRin    = w_s.MDRin;
    assign bus.IRin     = w_s.IRin;
    assign bus.Yin      = w_s.Yin;
    assign bus.Zin      = w_s.Zin;
    assign bus.LOin     = w_s.LOin;
    assign bus.HIin     = w_s.HIin;
    assign bus.IncPC    = w_s.IncPC;
    assign bus.Read     = w_s.Read;
    assign bus.Gra      = w_s.Gra;
    assign bus.Grb      = w_s.Grb;
    assign bus.Grc      = w_s.Grc;
    assign bus.Rin      = w_s.Rin;
    assign bus.Rout     = w_s.Rout;
    assign bus.alu_op   = w_alu_op;
    assign bus.run      = w_run;
    assign bus.illegal  = w_illegal;

endmodule
